// File: rtl/gate_edge_counter.sv
// gate_edge_counter
// -----------------
// Gated edge counter for the frequency meter. Counts rising edges of an
// asynchronous signal while a clk-synchronous gate window is high, and at
// each gate falling edge publishes the count with a one-cycle valid strobe
// and a saturation flag. With a window of N clk cycles the reported count
// is f_sig * N / f_clk.
//
// Parameters
//   CNT_WIDTH   : width of the edge accumulator and of count_o
//   SYNC_STAGES : flip-flop stages in the sig_i synchronizer (>= 2)
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   gate_i     : gate window, synchronous to clk, high = counting
//   sig_i      : measured signal, asynchronous to clk
//   count_o    : edge count of the last completed window, held until the
//                next publish
//   valid_o    : one-cycle strobe, count_o/overflow_o updated this cycle
//   overflow_o : last completed window saturated the accumulator
//   busy_o     : high while a window is being counted

module gate_edge_counter #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate_i,
  input  logic                 sig_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 valid_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // Synchronizer and edge-detect registers.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_q;
  logic                   gate_q;

  // FSM state, accumulator and registered outputs.
  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   acc_q;
  logic                   ovf_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic                   valid_q;
  logic                   overflow_q;
  logic                   busy_q;

  // Combinational helpers.
  logic                   sync_out;
  logic                   edge_det;
  logic                   gate_rise;
  logic                   gate_fall;
  logic                   acc_at_max;
  logic [CNT_WIDTH-1:0]   acc_start_d;
  logic [CNT_WIDTH-1:0]   acc_inc_d;

  // sig_i synchronizer: sync_q[0] is the first (metastable-capture) stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      sig_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_q  <= sync_out;
    end
  end

  // gate_q resets high so a gate already high at reset release does not
  // look like a rise; that partial window is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q <= 1'b1;
    end else begin
      gate_q <= gate_i;
    end
  end

  always_comb begin
    sync_out    = sync_q[SYNC_STAGES-1];
    edge_det    = sync_out & ~sig_q;
    gate_rise   = gate_i & ~gate_q;
    gate_fall   = ~gate_i & gate_q;
    acc_at_max  = &acc_q;
    acc_start_d = '0;
    acc_start_d[0] = edge_det;
    acc_inc_d   = acc_q + CNT_WIDTH'(1);
  end

  // Window FSM with registered outputs. busy_q tracks the state register
  // so busy_o is high exactly while in ST_COUNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gate_rise) begin
            state_q <= ST_COUNT;
            acc_q   <= acc_start_d;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (gate_fall) begin
            // An edge landing in the fall cycle is deliberately dropped.
            state_q    <= ST_IDLE;
            count_q    <= acc_q;
            overflow_q <= ovf_q;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
          end else if (gate_i && edge_det) begin
            if (acc_at_max) begin
              ovf_q <= 1'b1;
            end else begin
              acc_q <= acc_inc_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count_o    = count_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;
  assign busy_o     = busy_q;

endmodule
